// File: rtl/i2c_slave_sensor_if.sv
// i2c_slave_sensor_if: open-drain Scl/Sda bus shared by the I2C master and the sensor slave.
// Both sides only pull Sda low. The wired-AND with the pull-up is resolved here.
interface i2c_slave_sensor_if;
    logic scl;       // bus clock, driven by the master
    logic m_sda_oe;  // master pulls Sda low when set
    logic sda_oe;    // slave pulls Sda low when set (enable of a grounded bufif1)
    logic sda;       // resolved line level seen by both sides

    // Pulled-up open-drain line: low whenever either side enables its pull-down.
    assign sda = ~(m_sda_oe | sda_oe);

    modport slave  (input scl, input sda, output sda_oe);
    modport master (output scl, output m_sda_oe, input sda);
endinterface

// File: rtl/i2c_slave_sensor.sv
// i2c_slave_sensor: pointer-addressed LM75-style sensor on an I2C bus.
// Registers: 0 temperature (live input), 1 config, 2 T_low, 3 T_high.
// Scl/Sda are oversampled on i_clk. Sda is only ever pulled low, and only after an Scl falling edge.
module i2c_slave_sensor #(
    parameter logic [6:0]  ADR        = 7'h48,
    parameter logic [15:0] T_LOW_RST  = 16'h4B00,
    parameter logic [15:0] T_HIGH_RST = 16'h5000
) (
    input  logic              i_clk,
    input  logic              i_rst,
    i2c_slave_sensor_if.slave bus,
    input  logic [15:0]       i_temp,
    output logic [15:0]       o_config,
    output logic              o_alert,
    output logic              o_wr_done,
    output logic              o_busy
);

    typedef enum logic [3:0] {
        S_IDLE       = 4'd0,
        S_ADDR       = 4'd1,
        S_ADDR_ACK   = 4'd2,
        S_PTR        = 4'd3,
        S_PTR_ACK    = 4'd4,
        S_WR_MSB     = 4'd5,
        S_WR_MSB_ACK = 4'd6,
        S_WR_LSB     = 4'd7,
        S_WR_LSB_ACK = 4'd8,
        S_RD_MSB     = 4'd9,
        S_RD_MSB_ACK = 4'd10,
        S_RD_LSB     = 4'd11,
        S_RD_LSB_ACK = 4'd12,
        S_WAIT_STOP  = 4'd13
    } t_state;

    // Synchroniser and edge-detect stage.
    logic r_scl_s1, r_scl_s2, r_scl_q;
    logic r_sda_s1, r_sda_s2, r_sda_q;
    logic w_scl_rise, w_scl_fall, w_start, w_stop;

    // FSM.
    t_state r_state, w_state_nxt;
    logic   r_sda_oe, w_sda_oe_nxt;

    // Bit/byte handling.
    logic [3:0]  r_bit;
    logic [3:0]  w_bit_inc;
    logic        w_byte_done;
    logic        w_rx_state;
    logic [7:0]  r_shift;
    logic [7:0]  r_msb;
    logic [15:0] r_snap;
    logic [15:0] w_rd_val;
    logic        r_rw;
    logic        r_mack;
    logic        r_busy;
    logic [1:0]  r_ptr;

    // Register file and alarm.
    logic [15:0]        r_config, r_tlow, r_thigh;
    logic               r_wr_done;
    logic               r_alert;
    logic               w_commit;
    logic signed [15:0] w_temp_s, w_tlow_s, w_thigh_s;

    // Two-flop synchronisers plus one delayed copy for edge detection; idle bus reads high.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_scl_s1 <= 1'b1;
            r_scl_s2 <= 1'b1;
            r_scl_q  <= 1'b1;
            r_sda_s1 <= 1'b1;
            r_sda_s2 <= 1'b1;
            r_sda_q  <= 1'b1;
        end else begin
            r_scl_s1 <= bus.scl;
            r_scl_s2 <= r_scl_s1;
            r_scl_q  <= r_scl_s2;
            r_sda_s1 <= bus.sda;
            r_sda_s2 <= r_sda_s1;
            r_sda_q  <= r_sda_s2;
        end
    end

    assign w_scl_rise = r_scl_s2 & ~r_scl_q;
    assign w_scl_fall = ~r_scl_s2 & r_scl_q;
    // START/STOP need Scl high on both samples, so they never coincide with an Scl edge.
    assign w_start    = r_scl_s2 & r_scl_q & ~r_sda_s2 & r_sda_q;
    assign w_stop     = r_scl_s2 & r_scl_q & r_sda_s2 & ~r_sda_q;

    assign w_bit_inc   = r_bit + 4'd1;
    assign w_byte_done = (r_bit == 4'd8);
    assign w_rx_state  = (r_state == S_ADDR) || (r_state == S_PTR) ||
                         (r_state == S_WR_MSB) || (r_state == S_WR_LSB);

    // Read source for a snapshot: the live temperature for pointer 0, else the stored register.
    always_comb begin
        w_rd_val = i_temp;
        case (r_ptr)
            2'd1:    w_rd_val = r_config;
            2'd2:    w_rd_val = r_tlow;
            2'd3:    w_rd_val = r_thigh;
            default: w_rd_val = i_temp;
        endcase
    end

    // FSM state register; the Sda drive is registered with it so the pin never glitches.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= S_IDLE;
            r_sda_oe <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_sda_oe <= w_sda_oe_nxt;
        end
    end

    // FSM next-state: bus conditions first, otherwise byte decisions on Scl falling edges.
    always_comb begin
        w_state_nxt = r_state;
        if (w_stop) begin
            w_state_nxt = S_IDLE;
        end else if (w_start) begin
            w_state_nxt = S_ADDR;
        end else if (w_scl_fall) begin
            case (r_state)
                S_ADDR:       if (w_byte_done)
                                  w_state_nxt = (r_shift[7:1] == ADR) ? S_ADDR_ACK : S_WAIT_STOP;
                S_ADDR_ACK:   w_state_nxt = r_rw ? S_RD_MSB : S_PTR;
                S_PTR:        if (w_byte_done)
                                  w_state_nxt = (r_shift[7:2] == 6'd0) ? S_PTR_ACK : S_WAIT_STOP;
                S_PTR_ACK:    w_state_nxt = S_WR_MSB;
                S_WR_MSB:     if (w_byte_done) w_state_nxt = S_WR_MSB_ACK;
                S_WR_MSB_ACK: w_state_nxt = S_WR_LSB;
                S_WR_LSB:     if (w_byte_done) w_state_nxt = S_WR_LSB_ACK;
                S_WR_LSB_ACK: w_state_nxt = S_WAIT_STOP;
                S_RD_MSB:     if (r_bit == 4'd7) w_state_nxt = S_RD_MSB_ACK;
                S_RD_MSB_ACK: w_state_nxt = r_mack ? S_WAIT_STOP : S_RD_LSB;
                S_RD_LSB:     if (r_bit == 4'd7) w_state_nxt = S_RD_LSB_ACK;
                S_RD_LSB_ACK: w_state_nxt = r_mack ? S_WAIT_STOP : S_RD_MSB;
                default:      w_state_nxt = r_state;
            endcase
        end
    end

    // FSM output: next Sda drive, changed only on an Scl falling edge (or released on START/STOP).
    always_comb begin
        w_sda_oe_nxt = r_sda_oe;
        if (w_start || w_stop) begin
            w_sda_oe_nxt = 1'b0;
        end else if (w_scl_fall) begin
            case (w_state_nxt)
                S_ADDR_ACK, S_PTR_ACK, S_WR_MSB_ACK, S_WR_LSB_ACK:
                    w_sda_oe_nxt = 1'b1;
                // Entering a read byte drives its MSB; staying drives the next lower bit.
                S_RD_MSB: w_sda_oe_nxt = (r_state == S_RD_MSB) ? ~r_snap[4'd15 - w_bit_inc]
                                                                : ~w_rd_val[15];
                S_RD_LSB: w_sda_oe_nxt = (r_state == S_RD_LSB) ? ~r_snap[4'd7 - w_bit_inc]
                                                                : ~r_snap[7];
                default:  w_sda_oe_nxt = 1'b0;
            endcase
        end
    end

    // Transfer control: bit counter, R/W flag, master ACK, pointer and Busy.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_bit  <= 4'd0;
            r_rw   <= 1'b0;
            r_mack <= 1'b1;
            r_ptr  <= 2'd0;
            r_busy <= 1'b0;
        end else if (w_start || w_stop) begin
            r_bit  <= 4'd0;
            r_busy <= 1'b0;
        end else if (w_scl_rise) begin
            if (w_rx_state && !w_byte_done)
                r_bit <= w_bit_inc;
            if ((r_state == S_RD_MSB_ACK) || (r_state == S_RD_LSB_ACK))
                r_mack <= r_sda_s2;
        end else if (w_scl_fall) begin
            // Received bits count on rising edges, transmitted bits on falling edges.
            if (w_state_nxt != r_state)
                r_bit <= 4'd0;
            else if ((r_state == S_RD_MSB) || (r_state == S_RD_LSB))
                r_bit <= w_bit_inc;
            if ((r_state == S_ADDR) && (w_state_nxt == S_ADDR_ACK)) begin
                r_rw   <= r_shift[0];
                r_busy <= 1'b1;
            end
            if ((r_state == S_PTR) && (w_state_nxt == S_PTR_ACK))
                r_ptr <= r_shift[1:0];
        end
    end

    // Data staging: receive shifter, staged write MSB and the read snapshot.
    always_ff @(posedge i_clk) begin
        if (w_scl_rise && w_rx_state && !w_byte_done)
            r_shift <= {r_shift[6:0], r_sda_s2};
        if (w_scl_fall && (r_state == S_WR_MSB) && (w_state_nxt == S_WR_MSB_ACK))
            r_msb <= r_shift;
        if (w_scl_fall && (w_state_nxt == S_RD_MSB) && (r_state != S_RD_MSB))
            r_snap <= w_rd_val;
    end

    // The write commits as the data ACK clock ends; pointer 0 is read-only and is silently dropped.
    assign w_commit = w_scl_fall && (r_state == S_WR_LSB_ACK) && !i_rst;

    // Register file with a one-cycle Wr_done pulse on every effective write.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_config  <= 16'h0000;
            r_tlow    <= T_LOW_RST;
            r_thigh   <= T_HIGH_RST;
            r_wr_done <= 1'b0;
        end else begin
            r_wr_done <= w_commit && (r_ptr != 2'd0);
            if (w_commit) begin
                case (r_ptr)
                    2'd1:    r_config <= {r_msb, r_shift};
                    2'd2:    r_tlow   <= {r_msb, r_shift};
                    2'd3:    r_thigh  <= {r_msb, r_shift};
                    default: ;
                endcase
            end
        end
    end

    assign w_temp_s  = i_temp;
    assign w_tlow_s  = r_tlow;
    assign w_thigh_s = r_thigh;

    // Hysteretic alarm on signed temperature: set at/above T_high, clear below T_low.
    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_alert <= 1'b0;
        else if (w_temp_s >= w_thigh_s)
            r_alert <= 1'b1;
        else if (w_temp_s < w_tlow_s)
            r_alert <= 1'b0;
    end

    assign bus.sda_oe = r_sda_oe;
    assign o_config   = r_config;
    assign o_alert    = r_alert & r_config[0];
    assign o_wr_done  = r_wr_done;
    assign o_busy     = r_busy;

endmodule

// File: tb/tb_i2c_slave_sensor.sv
// tb_i2c_slave_sensor: directed I2C master transactions against the sensor slave.
module tb_i2c_slave_sensor;

    localparam int Q = 5;  // quarter Scl period in clk cycles (Scl = clk/20)

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] temp;
    logic [15:0] cfg;
    logic        alert, wr_done, busy;

    int n_total = 0;
    int n_bad   = 0;
    int wr_cnt  = 0;
    int drv_cnt = 0;

    i2c_slave_sensor_if bus_if();

    i2c_slave_sensor #(
        .ADR        (7'h48),
        .T_LOW_RST  (16'h4B00),
        .T_HIGH_RST (16'h5000)
    ) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .bus       (bus_if),
        .i_temp    (temp),
        .o_config  (cfg),
        .o_alert   (alert),
        .o_wr_done (wr_done),
        .o_busy    (busy)
    );

    always #5 clk = ~clk;

    // Count Wr_done pulses and cycles in which the slave pulls Sda low.
    always @(negedge clk) begin
        if (wr_done) wr_cnt = wr_cnt + 1;
        if (bus_if.sda_oe) drv_cnt = drv_cnt + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic wq;
        repeat (Q) @(posedge clk);
        #1;
    endtask

    // One Scl clock: master drives b (1 = release), returns the line level sampled while Scl is high.
    task automatic bit_x(input logic b, output logic r);
        wq; bus_if.m_sda_oe = ~b;
        wq; bus_if.scl = 1'b1;
        wq; r = bus_if.sda;
        wq; bus_if.scl = 1'b0;
    endtask

    task automatic i2c_start;
        wq; bus_if.m_sda_oe = 1'b0;
        wq; bus_if.scl = 1'b1;
        wq; bus_if.m_sda_oe = 1'b1;
        wq; bus_if.scl = 1'b0;
    endtask

    task automatic i2c_stop;
        wq; bus_if.m_sda_oe = 1'b1;
        wq; bus_if.scl = 1'b1;
        wq; bus_if.m_sda_oe = 1'b0;
        wq;
    endtask

    task automatic wr_byte(input logic [7:0] b, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) bit_x(b[i], r);
        bit_x(1'b1, r);
        ack = ~r;
    endtask

    task automatic rd_byte(input logic nack, output logic [7:0] b);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            bit_x(1'b1, r);
            b[i] = r;
        end
        bit_x(nack, r);
    endtask

    task automatic xfer_write(input logic [7:0] p, input logic [15:0] v, input string tag);
        logic a;
        i2c_start;
        wr_byte(8'h90, a);     check({tag, "_adr_ack"}, a, 1);
        wr_byte(p, a);         check({tag, "_ptr_ack"}, a, 1);
        wr_byte(v[15:8], a);   check({tag, "_msb_ack"}, a, 1);
        wr_byte(v[7:0], a);    check({tag, "_lsb_ack"}, a, 1);
        i2c_stop;
    endtask

    task automatic xfer_read(input logic [7:0] p, output logic [15:0] v, input string tag);
        logic a;
        logic [7:0] b;
        i2c_start;
        wr_byte(8'h90, a);     check({tag, "_adr_ack"}, a, 1);
        wr_byte(p, a);         check({tag, "_ptr_ack"}, a, 1);
        i2c_start;
        wr_byte(8'h91, a);     check({tag, "_radr_ack"}, a, 1);
        rd_byte(1'b0, b);      v[15:8] = b;
        rd_byte(1'b1, b);      v[7:0]  = b;
        i2c_stop;
    endtask

    initial begin
        logic        a;
        logic        r;
        logic [7:0]  b;
        logic [15:0] v;
        int          w0;
        int          d0;

        bus_if.scl = 1'b1;
        bus_if.m_sda_oe = 1'b0;
        temp = 16'h1940;
        rst = 1'b1;
        repeat (4) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        check("rst_config", cfg, 16'h0000);
        check("rst_alert", alert, 0);
        check("rst_busy", busy, 0);
        check("rst_wr_done", wr_done, 0);
        check("rst_sda_oe", bus_if.sda_oe, 0);
        xfer_read(8'h03, v, "rd_thi_rst");
        check("thi_rst_val", v, 16'h5000);

        // Two-byte write to T_high
        w0 = wr_cnt;
        i2c_start;
        wr_byte(8'h90, a);  check("w_adr_ack", a, 1);
        check("w_busy", busy, 1);
        wr_byte(8'h03, a);  check("w_ptr_ack", a, 1);
        wr_byte(8'h55, a);  check("w_msb_ack", a, 1);
        wr_byte(8'hAA, a);  check("w_lsb_ack", a, 1);
        i2c_stop;
        check("w_done_pulses", wr_cnt - w0, 1);
        check("w_busy_stop", busy, 0);
        xfer_read(8'h03, v, "rd_thi");
        check("thi_val", v, 16'h55AA);

        // Temperature read with wrap to the MSB, then master NACK
        temp = 16'h1940;
        i2c_start;
        wr_byte(8'h90, a);  check("r_adr_ack", a, 1);
        wr_byte(8'h00, a);  check("r_ptr_ack", a, 1);
        i2c_start;
        wr_byte(8'h91, a);  check("r_radr_ack", a, 1);
        rd_byte(1'b0, b);   check("r_msb", b, 8'h19);
        rd_byte(1'b0, b);   check("r_lsb", b, 8'h40);
        rd_byte(1'b1, b);   check("r_wrap_msb", b, 8'h19);
        wq;
        check("r_nack_release", bus_if.sda_oe, 0);
        check("r_busy_before_stop", busy, 1);
        i2c_stop;
        check("r_busy_after_stop", busy, 0);

        // Wrong address: no ACK, Sda never driven
        d0 = drv_cnt;
        i2c_start;
        wr_byte(8'h92, a);  check("bad_adr_nack", a, 0);
        check("bad_adr_busy", busy, 0);
        wr_byte(8'h00, a);  check("bad_adr_data_nack", a, 0);
        i2c_stop;
        check("bad_adr_no_drive", drv_cnt - d0, 0);
        i2c_start;
        wr_byte(8'h90, a);  check("good_adr_ack", a, 1);
        wr_byte(8'h03, a);  check("good_ptr_ack", a, 1);
        i2c_stop;

        // Out-of-range pointer is NACKed and the old pointer stays
        i2c_start;
        wr_byte(8'h90, a);  check("p7_adr_ack", a, 1);
        wr_byte(8'h07, a);  check("p7_nack", a, 0);
        i2c_stop;
        i2c_start;
        wr_byte(8'h91, a);  check("p7_radr_ack", a, 1);
        rd_byte(1'b0, b);   v[15:8] = b;
        rd_byte(1'b1, b);   v[7:0] = b;
        i2c_stop;
        check("p7_keeps_ptr", v, 16'h55AA);

        // Config write, pointer-0 discard, MSB-only abort
        w0 = wr_cnt;
        xfer_write(8'h03, 16'h5000, "w_thi");
        xfer_write(8'h01, 16'h0001, "w_cfg");
        check("cfg_val", cfg, 16'h0001);
        check("cfg_done_pulses", wr_cnt - w0, 2);
        w0 = wr_cnt;
        xfer_write(8'h00, 16'h1234, "w_ptr0");
        check("ptr0_no_done", wr_cnt - w0, 0);
        i2c_start;
        wr_byte(8'h90, a);  check("msbonly_adr_ack", a, 1);
        wr_byte(8'h02, a);  check("msbonly_ptr_ack", a, 1);
        wr_byte(8'h11, a);  check("msbonly_msb_ack", a, 1);
        i2c_stop;
        check("msbonly_no_done", wr_cnt - w0, 0);
        xfer_read(8'h02, v, "rd_tlo");
        check("msbonly_tlo_kept", v, 16'h4B00);

        // Hysteretic signed alert
        temp = 16'h5000; repeat (3) @(posedge clk); #1;
        check("alert_set_at_thigh", alert, 1);
        temp = 16'h4C00; repeat (3) @(posedge clk); #1;
        check("alert_hold_between", alert, 1);
        temp = 16'h4AFF; repeat (3) @(posedge clk); #1;
        check("alert_clear_below_tlow", alert, 0);
        temp = 16'h8000; repeat (3) @(posedge clk); #1;
        check("alert_negative", alert, 0);

        // Reset in the middle of a read byte
        temp = 16'h0000;
        i2c_start;
        wr_byte(8'h90, a);  check("mid_adr_ack", a, 1);
        wr_byte(8'h00, a);  check("mid_ptr_ack", a, 1);
        i2c_start;
        wr_byte(8'h91, a);  check("mid_radr_ack", a, 1);
        bit_x(1'b1, r);
        bit_x(1'b1, r);
        bit_x(1'b1, r);
        wq;
        check("mid_slave_driving", bus_if.sda_oe, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_release", bus_if.sda_oe, 0);
        check("mid_rst_config", cfg, 16'h0000);
        rst = 1'b0;
        check("mid_rst_alert", alert, 0);
        i2c_stop;
        check("mid_rst_busy", busy, 0);
        xfer_read(8'h03, v, "post_rst");
        check("post_rst_thi", v, 16'h5000);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
